mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_mc_pkg.sv | 30 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
//
// Shared definitions for the multi-cycle MIPS memory access path.
//   - DataWDefault : default data/address width
//   - OpMsb/OpLsb  : opcode field bounds inside the instruction word
//   - mc_state_e   : memory access FSM state type
//   - addr_misaligned() : word alignment test on the two address LSBs
// -----------------------------------------------------------------------------
package mips_mc_pkg;

  localparam int unsigned DataWDefault = 32;

  // Opcode field of the instruction word.
  localparam int unsigned OpMsb = 31;
  localparam int unsigned OpLsb = 26;
  localparam int unsigned OpW   = OpMsb - OpLsb + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mc_state_e;

  // A word access is misaligned when either of the byte-offset bits is set.
  function automatic logic addr_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Bridges the multi-cycle MIPS control unit to an external memory with an
// acknowledge handshake. Each MemRead/MemWrite control state is stretched
// over IDLE -> BUSY (until mem_ack) -> DONE while stall holds the control
// unit's state register. Read data lands in ir (IRwrite=1) or mdr.
//
// Parameters
//   DATA_W      data and address width (>= 32, opcode sits in ir[31:26])
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      control-unit MemRead / MemWrite
//   ior_d, ir_write          control-unit IorD / IRwrite
//   pc, alu_out, wdata       fetch address, data address, store data
//   stall                    holds the control-unit state register
//   ir, mdr, op              instruction register, data register, ir[31:26]
//   mem_req, mem_we          external request and write enable
//   mem_addr, mem_wdata      external request address and store data
//   mem_rdata, mem_ack       external response (ack valid only with mem_req)
//   align_err                one-cycle misalignment pulse
//
// Configuration
//   MEM_ALIGN_CHECK_EN defined : misaligned accesses are refused, align_err
//                                pulses and the control unit is released.
//   MEM_ALIGN_CHECK_EN undefined: address LSBs are forced to 00 and
//                                align_err is tied low.
// -----------------------------------------------------------------------------
module mem_access_unit
  import mips_mc_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,

  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [OpW-1:0]    op,

  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic              align_err
);

  mc_state_e         state_q;
  logic              access;
  logic [DATA_W-1:0] sel_addr;

  assign access   = mem_read | mem_write;
  assign sel_addr = ior_d ? alu_out : pc;

  // Released in DONE so the control unit advances exactly once per access.
  assign stall = access & (state_q != StDone);
  assign op    = ir[OpMsb:OpLsb];

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (access) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (addr_misaligned(sel_addr[1:0])) begin
              // Refuse the access: no request, just flag it and let the
              // control unit move on.
              align_err_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              mem_addr  <= sel_addr;
              mem_we    <= mem_write;
              mem_wdata <= wdata;
              mem_req   <= 1'b1;
              state_q   <= StBusy;
            end
`else
            mem_addr  <= {sel_addr[DATA_W-1:2], 2'b00};
            // Write wins when both strobes are set.
            mem_we    <= mem_write;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            state_q   <= StBusy;
`endif
          end
        end

        StBusy: begin
          if (mem_ack) begin
            // mem_we is the registered request type, so a read+write
            // request never captures data.
            if (!mem_we) begin
              if (ir_write) begin
                ir <= mem_rdata;
              end else begin
                mdr <= mem_rdata;
              end
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state_q <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // A request exists only while waiting for the acknowledge.
  a_req_only_busy: assert property (@(posedge clk) disable iff (rst)
    mem_req |-> (state_q == StBusy));

  // Request fields hold steady until the acknowledge.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ack) |=> ($stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ior_d, ir_write;
  logic [31:0] pc, alu_out, wdata;
  logic        stall;
  logic [31:0] ir, mdr;
  logic [5:0]  op;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        align_err;

  mem_access_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .ior_d    (ior_d),
    .ir_write (ir_write),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .stall    (stall),
    .ir       (ir),
    .mdr      (mdr),
    .op       (op),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle view, written by the stimulus side from the
  // transaction rules (1 IDLE cycle, waits+1 BUSY cycles, 1 DONE cycle).
  bit          exp_valid = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_align;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] m_ir = 32'h0;
  logic [31:0] m_mdr = 32'h0;

  // Observation counters used by the literal pins.
  int          stall_cnt = 0;
  int          req_cnt   = 0;
  int          align_cnt = 0;
  logic [31:0] last_addr  = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_we    = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      chk("align_err", {31'b0, align_err}, {31'b0, exp_align});
      chk("ir", ir, m_ir);
      chk("mdr", mdr, m_mdr);
      chk("op", {26'b0, op}, {26'b0, m_ir[31:26]});
      if (exp_req) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
      if (align_err) align_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
  end

  task automatic set_exp(input logic s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic al);
    exp_stall = s;
    exp_req   = r;
    exp_we    = w;
    exp_addr  = a;
    exp_wdata = d;
    exp_align = al;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic iord, input logic irw,
                        input logic [31:0] pcv, input logic [31:0] aluv,
                        input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    logic [31:0] ea;
    bit          mis;
    ea = iord ? aluv : pcv;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (ea[1:0] != 2'b00);
`else
    mis = 1'b0;
    ea[1:0] = 2'b00;
`endif
    stall_cnt = 0;
    mem_read  = rd;
    mem_write = wr;
    ior_d     = iord;
    ir_write  = irw;
    pc        = pcv;
    alu_out   = aluv;
    wdata     = wd;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);  // IDLE
    next_cycle();
    if (mis) begin
      set_exp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);  // straight to DONE
    end else begin
      for (int i = 0; i <= waits; i++) begin
        set_exp(1'b1, 1'b1, wr, ea, wd, 1'b0);  // BUSY
        mem_ack   = (i == waits);
        mem_rdata = (i == waits) ? rdata : $urandom;
        next_cycle();
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!wr) begin
        if (irw) m_ir = rdata;
        else     m_mdr = rdata;
      end
      set_exp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);  // DONE
    end
    next_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);  // back in IDLE, no op
    next_cycle();
  endtask

  int req_before;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ior_d     = 1'b0;
    ir_write  = 1'b0;
    pc        = 32'h0;
    alu_out   = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state.
    chk("rst_ir", ir, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_op", {26'b0, op}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_align", {31'b0, align_err}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    set_exp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_valid = 1'b1;
    next_cycle();

    // Instruction fetch, zero-wait ack.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0777, 32'h0, 0, 32'h8C22_0004);
    chk("fetch_addr", last_addr, 32'h0000_0010);
    chk("fetch_stall_cycles", stall_cnt, 32'd2);
    chk("fetch_ir", ir, 32'h8C22_0004);
    chk("fetch_op", {26'b0, op}, 32'h23);

    // lw data read with 3 wait cycles.
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF);
    chk("lw_addr", last_addr, 32'h0000_0104);
    chk("lw_stall_cycles", stall_cnt, 32'd5);
    chk("lw_mdr", mdr, 32'hDEAD_BEEF);
    chk("lw_ir_kept", ir, 32'h8C22_0004);

    // sw with one wait cycle; read data on the bus must be ignored.
    access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0018, 32'h0000_0200, 32'h1234_5678, 1,
           32'hCAFE_F00D);
    chk("sw_we", {31'b0, last_we}, 32'h1);
    chk("sw_wdata", last_wdata, 32'h1234_5678);
    chk("sw_addr", last_addr, 32'h0000_0200);
    chk("sw_mdr_kept", mdr, 32'hDEAD_BEEF);

    // Read and write together: write wins, nothing captured.
    access(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_001C, 32'h0000_0300, 32'hA5A5_A5A5, 0,
           32'h0BAD_F00D);
    chk("rw_we", {31'b0, last_we}, 32'h1);
    chk("rw_ir_kept", ir, 32'h8C22_0004);
    chk("rw_mdr_kept", mdr, 32'hDEAD_BEEF);

    // Misaligned data read.
    req_before = req_cnt;
    align_cnt  = 0;
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0102, 32'h0, 0, 32'h55AA_55AA);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_no_req", req_cnt - req_before, 32'd0);
    chk("mis_align_pulses", align_cnt, 32'd1);
    chk("mis_stall_cycles", stall_cnt, 32'd1);
    chk("mis_mdr_kept", mdr, 32'hDEAD_BEEF);
`else
    chk("mis_addr_forced", last_addr, 32'h0000_0100);
    chk("mis_align_pulses", align_cnt, 32'd0);
    chk("mis_mdr", mdr, 32'h55AA_55AA);
`endif

    // Reset in BUSY, then a late acknowledge.
    mem_read = 1'b1;
    ior_d    = 1'b0;
    ir_write = 1'b1;
    pc       = 32'h0000_0040;
    set_exp(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    set_exp(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst       = 1'b0;
    mem_read  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    m_ir      = 32'h0;
    m_mdr     = 32'h0;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rbusy_addr", mem_addr, 32'h0);
    chk("rbusy_we", {31'b0, mem_we}, 32'h0);
    next_cycle();
    mem_ack = 1'b0;
    chk("late_ack_req", {31'b0, mem_req}, 32'h0);
    chk("late_ack_ir", ir, 32'h0);
    chk("late_ack_mdr", mdr, 32'h0);
    next_cycle();

    // Normal fetch after the abandoned access.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0, 2, 32'h0200_4020);
    chk("refetch_ir", ir, 32'h0200_4020);
    chk("refetch_op", {26'b0, op}, 32'h0);

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
